// File: rtl/uv_sched_pkg.sv
// Shared constants and derr field helpers for the chroma reconstruct sequencer.
package uv_sched_pkg;

  // Sequencer states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_IN = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  // Signed error field width; left/top entries hold 2 ch x 2 fields
  localparam int DW = 8;
  localparam int EW = 4 * DW;

  // LSB of datapath error field e[ch][k]
  function automatic int derr_lsb(input int ch, input int k);
    return DW * (3 * ch + k);
  endfunction

  // LSB of left/top entry field f[ch][j]
  function automatic int ent_lsb(input int ch, input int j);
    return 2 * DW * ch + DW * j;
  endfunction

  // (3*e2)>>>2 at 10-bit signed, truncated back to the field width
  function automatic logic [DW-1:0] left_upd(input logic [DW-1:0] e2);
    logic signed [DW+1:0] t;
    t = {{2{e2[DW-1]}}, e2};
    t = t + (t <<< 1);
    return DW'(t >>> 2);
  endfunction

endpackage

// File: rtl/uv_derr_line_buf.sv
// Top-error line buffer: one write port, one registered read port.
// A read and write to the same index in one cycle returns the old entry.
module uv_derr_line_buf
  import uv_sched_pkg::*;
#(
  parameter int MAX_MB_W = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [9:0]    waddr,
  input  logic [EW-1:0] wdata,
  input  logic          re,
  input  logic [9:0]    raddr,
  output logic [EW-1:0] rdata
);

  localparam int AW = (MAX_MB_W > 1) ? $clog2(MAX_MB_W) : 1;

  logic [EW-1:0] mem_q [MAX_MB_W];
  logic [EW-1:0] rdata_q;

  // Write port; out-of-range indices are dropped
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < 11'(MAX_MB_W))) mem_q[waddr[AW-1:0]] <= wdata;
  end

  // Registered read, held between reads
  always_ff @(posedge clk) begin
    if (re) rdata_q <= ({1'b0, raddr} < 11'(MAX_MB_W)) ? mem_q[raddr[AW-1:0]] : '0;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uv_recon_sched.sv
// Frame-level sequencer for the chroma reconstruct datapath. Walks MBs in
// raster order, owns the diffusion-error left register and top line buffer,
// and holds each result until downstream accepts it.
module uv_recon_sched
  import uv_sched_pkg::*;
#(
  parameter int MAX_MB_W = 256,
  parameter int TIMEOUT  = 4096,
  parameter int TW       = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [9:0]  mb_w,
  input  logic [9:0]  mb_h,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        rc_start,
  output logic [9:0]  rc_x,
  output logic [9:0]  rc_y,
  input  logic        rc_top_derr_en,
  input  logic [9:0]  rc_top_derr_addr,
  output logic [31:0] rc_top_derr,
  output logic [31:0] rc_left_derr,
  input  logic [47:0] rc_derr,
  input  logic        rc_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y
);

  logic [2:0]    state_q, state_d;
  logic [9:0]    w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic          err_q, err_d, fd_q, fd_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   left_q, left_d;
  logic          tz_q, tz_d;   // last top read must return zero
  logic [31:0]   left_new, top_new, buf_rdata;
  logic          buf_we;

  // Commit arithmetic for both chroma channels
  always_comb begin
    left_new = '0;
    top_new  = '0;
    for (int ch = 0; ch < 2; ch++) begin
      left_new[ent_lsb(ch, 0) +: DW] = rc_derr[derr_lsb(ch, 0) +: DW];
      left_new[ent_lsb(ch, 1) +: DW] = left_upd(rc_derr[derr_lsb(ch, 2) +: DW]);
      top_new[ent_lsb(ch, 0) +: DW]  = rc_derr[derr_lsb(ch, 1) +: DW];
      top_new[ent_lsb(ch, 1) +: DW]  = rc_derr[derr_lsb(ch, 2) +: DW]
                                     - left_upd(rc_derr[derr_lsb(ch, 2) +: DW]);
    end
  end

  // Next-state and datapath bookkeeping
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    fd_d    = 1'b0;
    cnt_d   = cnt_q;
    left_d  = left_q;
    tz_d    = tz_q;
    buf_we  = 1'b0;
    // Row 0 has no row above; indices past the frame width read as empty
    if (rc_top_derr_en) tz_d = (y_q == 10'd0) || (rc_top_derr_addr >= w_q);
    case (state_q)
      S_IDLE: if (frame_start) begin
        w_d   = mb_w;
        h_d   = mb_h;
        x_d   = '0;
        y_d   = '0;
        err_d = 1'b0;
        if (mb_w == 10'd0 || mb_h == 10'd0) fd_d = 1'b1;
        else if ({1'b0, mb_w} > 11'(MAX_MB_W)) begin
          err_d = 1'b1;
          fd_d  = 1'b1;
        end else state_d = S_WAIT_IN;
      end
      S_WAIT_IN: if (in_valid) begin
        state_d = S_START;
        if (x_q == 10'd0) left_d = '0;
      end
      S_START: begin
        cnt_d   = TW'(1);   // the start cycle counts toward the timeout
        state_d = S_RUN;
      end
      S_RUN: begin
        if (rc_done) state_d = S_COMMIT;
        else if (cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          fd_d    = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_COMMIT: begin
        left_d  = left_new;
        buf_we  = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: if (out_ready) begin
        if (x_q == w_q - 10'd1) begin
          x_d = '0;
          if (y_q == h_q - 10'd1) begin
            fd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            y_d     = y_q + 10'd1;
            state_d = S_WAIT_IN;
          end
        end else begin
          x_d     = x_q + 10'd1;
          state_d = S_WAIT_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
      left_q  <= '0;
      tz_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      tz_q    <= tz_d;
    end
  end

  uv_derr_line_buf #(.MAX_MB_W(MAX_MB_W)) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (x_q),
    .wdata (top_new),
    .re    (rc_top_derr_en),
    .raddr (rc_top_derr_addr),
    .rdata (buf_rdata)
  );

  assign busy         = (state_q != S_IDLE);
  assign frame_done   = fd_q;
  assign err          = err_q;
  assign in_ready     = (state_q == S_WAIT_IN);
  assign rc_start     = (state_q == S_START);
  assign rc_x         = x_q;
  assign rc_y         = y_q;
  assign rc_top_derr  = tz_q ? '0 : buf_rdata;
  assign rc_left_derr = left_q;
  assign out_valid    = (state_q == S_OUT);
  assign out_x        = x_q;
  assign out_y        = y_q;

endmodule
